// File: rtl/viterbi_pkg.sv
// Shared sizing constants and the sequencer state encoding for the Viterbi datapath.
package viterbi_pkg;
   localparam int WORD_NUM     = 16;
   localparam int WORD_NUM_BIT = 4;
   localparam int POS_NUM      = 11;
   localparam int POS_NUM_BIT  = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RECUR,
      S_FINAL,
      S_BACKTRACK,
      S_DONE
   } vseq_state_t;
endpackage

// File: rtl/pos_wrap_counter.sv
// POS tag counter: clear > load > increment, wrapping at POS_num-1; registered, 1-cycle update.
// wrap is a flag decoded from the current count, so it is valid in the same cycle as the count.
module pos_wrap_counter
   import viterbi_pkg::*;
#(
   parameter int POS_num     = POS_NUM,
   parameter int POS_num_bit = POS_NUM_BIT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   input  logic                   load,
   input  logic [POS_num_bit-1:0] load_val,
   output logic [POS_num_bit-1:0] cnt,
   output logic                   wrap
);
   localparam logic [POS_num_bit-1:0] CNT_MAX = POS_num_bit'(POS_num - 1);

   assign wrap = (cnt == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en)
         cnt <= wrap ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/viterbi_sequencer.sv
// Trellis walk scheduler (INIT, RECUR, FINAL, optional BACKTRACK when VITERBI_BACKTRACK_EN is defined).
// Registered state outputs, one step per cycle; stall holds all state and masks every strobe.
module viterbi_sequencer
   import viterbi_pkg::*;
#(
   parameter int word_num     = WORD_NUM,
   parameter int word_num_bit = WORD_NUM_BIT,
   parameter int POS_num      = POS_NUM,
   parameter int POS_num_bit  = POS_NUM_BIT
) (
   input  logic                    clk,
   input  logic                    reset_viterbi_sequencer,
   input  logic                    start,
   input  logic [word_num_bit:0]   word_count,
   input  logic                    stall,
   input  logic [POS_num_bit-1:0]  best_last_pos,
   input  logic [POS_num_bit-1:0]  bp_data,
   output logic                    busy,
   output logic                    done,
   output logic [word_num_bit-1:0] word_idx,
   output logic [POS_num_bit-1:0]  cur_pos,
   output logic [POS_num_bit-1:0]  prev_pos,
   output logic                    init_valid,
   output logic                    acc_valid,
   output logic                    acc_first,
   output logic                    acc_last,
   output logic                    bt_valid
);
   localparam logic [word_num_bit:0] WORD_MAX = (word_num_bit + 1)'(word_num);

   vseq_state_t             state, state_nxt;
   logic [word_num_bit-1:0] word_q, word_nxt;
   logic [word_num_bit-1:0] last_q, last_nxt;
   logic [word_num_bit:0]   wc_clamp;
   logic                    prev_en, prev_clr, prev_wrap;
   logic                    cur_en, cur_clr, cur_load, cur_wrap;
   logic [POS_num_bit-1:0]  cur_load_val;

   assign wc_clamp = (word_count > WORD_MAX) ? WORD_MAX : word_count;

   always_ff @(posedge clk or posedge reset_viterbi_sequencer) begin
      if (reset_viterbi_sequencer) begin
         state  <= S_IDLE;
         word_q <= '0;
         last_q <= '0;
      end else begin
         state  <= state_nxt;
         word_q <= word_nxt;
         last_q <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      word_nxt  = word_q;
      last_nxt  = last_q;
      prev_en   = 1'b0;
      prev_clr  = 1'b0;
      cur_en    = 1'b0;
      cur_clr   = 1'b0;
      cur_load  = 1'b0;
      if (!stall) begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  prev_clr = 1'b1;
                  cur_clr  = 1'b1;
                  word_nxt = '0;
                  if (word_count == '0) begin
                     state_nxt = S_DONE;
                  end else begin
                     last_nxt  = word_num_bit'(wc_clamp - 1'b1);
                     state_nxt = S_INIT;
                  end
               end
            end
            S_INIT: begin
               cur_en = 1'b1;
               if (cur_wrap) begin
                  if (last_q != '0) begin
                     word_nxt  = word_num_bit'(1);
                     state_nxt = S_RECUR;
                  end else begin
                     state_nxt = S_FINAL;
                  end
               end
            end
            S_RECUR: begin
               // prev_pos is innermost; cur_pos and word_idx advance on its carry
               prev_en = 1'b1;
               cur_en  = prev_wrap;
               if (prev_wrap && cur_wrap) begin
                  if (word_q == last_q)
                     state_nxt = S_FINAL;
                  else
                     word_nxt = word_q + 1'b1;
               end
            end
`ifdef VITERBI_BACKTRACK_EN
            S_FINAL: begin
               cur_load  = 1'b1;
               word_nxt  = last_q;
               state_nxt = S_BACKTRACK;
            end
            S_BACKTRACK: begin
               cur_load = 1'b1;
               word_nxt = word_q - 1'b1;
               if (word_q == '0)
                  state_nxt = S_DONE;
            end
`else
            S_FINAL: begin
               state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
               prev_clr  = 1'b1;
               cur_clr   = 1'b1;
               word_nxt  = '0;
               state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

`ifdef VITERBI_BACKTRACK_EN
   assign cur_load_val = (state == S_FINAL) ? best_last_pos : bp_data;
   assign bt_valid     = (state == S_BACKTRACK) && !stall;
`else
   logic unused_bt_inputs;
   assign unused_bt_inputs = ^{best_last_pos, bp_data};
   assign cur_load_val     = '0;
   assign bt_valid         = 1'b0;
`endif

   pos_wrap_counter #(.POS_num(POS_num), .POS_num_bit(POS_num_bit)) u_prev_cnt (
      .clk      (clk),
      .rst      (reset_viterbi_sequencer),
      .en       (prev_en),
      .clr      (prev_clr),
      .load     (1'b0),
      .load_val ('0),
      .cnt      (prev_pos),
      .wrap     (prev_wrap)
   );

   pos_wrap_counter #(.POS_num(POS_num), .POS_num_bit(POS_num_bit)) u_cur_cnt (
      .clk      (clk),
      .rst      (reset_viterbi_sequencer),
      .en       (cur_en),
      .clr      (cur_clr),
      .load     (cur_load),
      .load_val (cur_load_val),
      .cnt      (cur_pos),
      .wrap     (cur_wrap)
   );

   assign word_idx   = word_q;
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE) && !stall;
   assign init_valid = (state == S_INIT) && !stall;
   assign acc_valid  = (state == S_RECUR) && !stall;
   assign acc_first  = acc_valid && (prev_pos == '0);
   assign acc_last   = acc_valid && prev_wrap;
endmodule

// File: tb/tb_viterbi_sequencer.sv
// Bench for viterbi_sequencer: randomized decodes against a loop-nest reference of the trellis walk.
module tb_viterbi_sequencer;
`ifdef VITERBI_BACKTRACK_EN
   localparam bit BT_EN = 1'b1;
`else
   localparam bit BT_EN = 1'b0;
`endif
   localparam int P = 11;

   typedef struct packed {
      logic [2:0] kind;  // {init, acc, bt}
      logic [3:0] w;
      logic [3:0] j;
      logic [3:0] i;
      logic       f;
      logic       l;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] word_count;
   logic       stall;
   logic [3:0] best_last_pos;
   logic [3:0] bp_data;
   logic       busy, done, init_valid, acc_valid, acc_first, acc_last, bt_valid;
   logic [3:0] word_idx, cur_pos, prev_pos;

   logic [3:0] bp_tab [0:15][0:15];
   ev_t        exp_q[$];
   ev_t        obs_q[$];
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   assign bp_data = bp_tab[word_idx][cur_pos];

   viterbi_sequencer dut (
      .clk                     (clk),
      .reset_viterbi_sequencer (rst),
      .start                   (start),
      .word_count              (word_count),
      .stall                   (stall),
      .best_last_pos           (best_last_pos),
      .bp_data                 (bp_data),
      .busy                    (busy),
      .done                    (done),
      .word_idx                (word_idx),
      .cur_pos                 (cur_pos),
      .prev_pos                (prev_pos),
      .init_valid              (init_valid),
      .acc_valid               (acc_valid),
      .acc_first               (acc_first),
      .acc_last                (acc_last),
      .bt_valid                (bt_valid)
   );

   function automatic ev_t mk(input logic [2:0] k, input logic [3:0] w, input logic [3:0] j,
                              input logic [3:0] i, input logic f, input logic l);
      ev_t e;
      e.kind = k; e.w = w; e.j = j; e.i = i; e.f = f; e.l = l;
      return e;
   endfunction

   function automatic int clampl(input int L);
      return (L > 16) ? 16 : L;
   endfunction

   // Expected strobe sequence straight from the trellis loop nest.
   task automatic build_model(input int L, input logic [3:0] best);
      int n = clampl(L);
      logic [3:0] tag;
      exp_q.delete();
      if (n == 0) return;
      for (int j = 0; j < P; j++)
         exp_q.push_back(mk(3'b100, 4'd0, 4'(j), 4'd0, 1'b0, 1'b0));
      for (int t = 1; t < n; t++)
         for (int j = 0; j < P; j++)
            for (int i = 0; i < P; i++)
               exp_q.push_back(mk(3'b010, 4'(t), 4'(j), 4'(i), i == 0, i == P - 1));
      if (BT_EN) begin
         tag = best;
         for (int t = n - 1; t >= 0; t--) begin
            exp_q.push_back(mk(3'b001, 4'(t), tag, 4'd0, 1'b0, 1'b0));
            tag = bp_tab[t][tag];
         end
      end
   endtask

   // Cycles from the start cycle through the done cycle, inclusive.
   function automatic int exp_lat(input int L);
      int n = clampl(L);
      if (n == 0) return 2;
      return 1 + P + (n - 1) * P * P + 1 + (BT_EN ? n : 0) + 1;
   endfunction

   function automatic int seq_diff();
      int n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         if (k >= obs_q.size() || k >= exp_q.size()) return k;
         if (obs_q[k] !== exp_q[k]) return k;
      end
      return -1;
   endfunction

   function automatic ev_t obs_at(input int k);
      return (k >= 0 && k < obs_q.size()) ? obs_q[k] : '0;
   endfunction

   function automatic ev_t exp_at(input int k);
      return (k >= 0 && k < exp_q.size()) ? exp_q[k] : '0;
   endfunction

   task automatic run_decode(input int L, input logic [3:0] best, input int stall_cyc,
                             input int stall_len, input bit hold_start,
                             output int lat, output bit busy_ok, output logic busy_after);
      int cyc = 0;
      lat = -1;
      busy_ok = 1'b1;
      obs_q.delete();
      best_last_pos = best;
      @(negedge clk);
      start = 1'b1;
      word_count = 5'(L);
      while (cyc < 4000) begin
         @(posedge clk);
         #1;
         cyc++;
         start = hold_start;
         if (hold_start) word_count = 5'($urandom_range(0, 31));
         stall = (stall_len > 0) && (cyc >= stall_cyc) && (cyc < stall_cyc + stall_len);
         @(negedge clk);
         if (!busy) busy_ok = 1'b0;
         if (init_valid || acc_valid || bt_valid || acc_first || acc_last)
            obs_q.push_back(mk({init_valid, acc_valid, bt_valid}, word_idx, cur_pos, prev_pos,
                               acc_first, acc_last));
         if (done) begin
            lat = cyc + 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      busy_after = busy;
   endtask

   task automatic test_reset;
      int d, lat;
      bit bok;
      logic ba;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if ({word_idx, cur_pos, prev_pos} !== 12'h0) begin
         errors++; $display("FAIL reset_idx: got %h want 000", {word_idx, cur_pos, prev_pos});
      end
      checks++;
      if ({done, init_valid, acc_valid, acc_first, acc_last, bt_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 000000",
                  {done, init_valid, acc_valid, acc_first, acc_last, bt_valid});
      end
      @(negedge clk);
      rst = 1'b0;

      // Reset landing in the middle of RECUR.
      @(negedge clk);
      start = 1'b1;
      word_count = 5'd3;
      repeat (40) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      checks++;
      if (acc_valid !== 1'b1) begin errors++; $display("FAIL mid_recur: acc_valid got %b want 1", acc_valid); end
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      checks++;
      if ({word_idx, cur_pos, prev_pos, acc_valid} !== 13'h0) begin
         errors++;
         $display("FAIL midrst_idx: got %h want 0000", {word_idx, cur_pos, prev_pos, acc_valid});
      end
      @(negedge clk);
      rst = 1'b0;

      build_model(1, 4'd5);
      run_decode(1, 4'd5, 0, 0, 1'b0, lat, bok, ba);
      checks++;
      if (obs_at(0) !== mk(3'b100, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0)) begin
         errors++; $display("FAIL restart_first: got %h want %h", obs_at(0), mk(3'b100, 0, 0, 0, 0, 0));
      end
      d = seq_diff();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL restart_seq: event %0d got %h want %h (%0d vs %0d events)",
                  d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
      end
   endtask

   task automatic test_l2;
      int d, lat;
      bit bok;
      logic ba;
      logic [3:0] best = 4'($urandom_range(0, P - 1));
      build_model(2, best);
      run_decode(2, best, 0, 0, 1'b0, lat, bok, ba);
      d = seq_diff();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL l2_seq: event %0d got %h want %h (%0d vs %0d events)",
                  d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
      end
      checks++;
      if (lat !== exp_lat(2)) begin errors++; $display("FAIL l2_latency: got %0d want %0d", lat, exp_lat(2)); end
      checks++;
      if (bok !== 1'b1) begin errors++; $display("FAIL l2_busy_during: busy dropped before done"); end
      checks++;
      if (ba !== 1'b0) begin errors++; $display("FAIL l2_busy_after: got %b want 0", ba); end
   endtask

   task automatic test_l1;
      int d, lat;
      bit bok;
      logic ba;
      logic [3:0] best = 4'($urandom_range(0, P - 1));
      build_model(1, best);
      run_decode(1, best, 0, 0, 1'b0, lat, bok, ba);
      d = seq_diff();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL l1_seq: event %0d got %h want %h (%0d vs %0d events)",
                  d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
      end
      checks++;
      if (lat !== exp_lat(1)) begin errors++; $display("FAIL l1_latency: got %0d want %0d", lat, exp_lat(1)); end
   endtask

   task automatic test_backtrace;
      int d, lat;
      bit bok;
      logic ba;
      bp_tab[3][7] = 4'd3;
      bp_tab[2][3] = 4'd9;
      bp_tab[1][9] = 4'd0;
      build_model(4, 4'd7);
      run_decode(4, 4'd7, 0, 0, 1'b0, lat, bok, ba);
      d = seq_diff();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL bt_chain_seq: event %0d got %h want %h (%0d vs %0d events)",
                  d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
      end
      checks++;
      if (lat !== exp_lat(4)) begin errors++; $display("FAIL bt_chain_latency: got %0d want %0d", lat, exp_lat(4)); end
   endtask

   task automatic test_stall;
      int d, lat, idx = -1;
      bit bok;
      logic ba;
      logic [3:0] best = 4'($urandom_range(0, P - 1));
      build_model(2, best);
      foreach (exp_q[k])
         if (idx < 0 && exp_q[k] == mk(3'b010, 4'd1, 4'd4, 4'd10, 1'b0, 1'b1)) idx = k;
      run_decode(2, best, idx + 1, 5, 1'b0, lat, bok, ba);
      d = seq_diff();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL stall_seq: event %0d got %h want %h (%0d vs %0d events)",
                  d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
      end
      checks++;
      if (lat !== exp_lat(2) + 5) begin errors++; $display("FAIL stall_latency: got %0d want %0d", lat, exp_lat(2) + 5); end
   endtask

   task automatic test_edges;
      int d, lat;
      bit bok;
      logic ba;
      logic [3:0] best = 4'($urandom_range(0, P - 1));
      build_model(0, best);
      run_decode(0, best, 0, 0, 1'b0, lat, bok, ba);
      checks++;
      if (obs_q.size() !== 0) begin errors++; $display("FAIL zero_len_events: got %0d want 0", obs_q.size()); end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL zero_len_latency: got %0d want 2", lat); end

      build_model(20, best);
      run_decode(20, best, 0, 0, 1'b0, lat, bok, ba);
      d = seq_diff();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL clamp_seq: event %0d got %h want %h (%0d vs %0d events)",
                  d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
      end
      checks++;
      if (lat !== exp_lat(16)) begin errors++; $display("FAIL clamp_latency: got %0d want %0d", lat, exp_lat(16)); end

      // start held high (with changing word_count) for the whole decode, including DONE
      build_model(3, best);
      run_decode(3, best, 0, 0, 1'b1, lat, bok, ba);
      d = seq_diff();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL busy_start_seq: event %0d got %h want %h (%0d vs %0d events)",
                  d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
      end
      checks++;
      if (lat !== exp_lat(3)) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", lat, exp_lat(3)); end
      checks++;
      if (ba !== 1'b0) begin errors++; $display("FAIL start_in_done: busy after got %b want 0", ba); end
   endtask

   task automatic test_random;
      int d, lat, L, sc, sl;
      bit bok;
      logic ba;
      logic [3:0] best;
      for (int r = 0; r < 5; r++) begin
         L = $urandom_range(0, 5);
         best = 4'($urandom_range(0, P - 1));
         sl = $urandom_range(0, 6);
         sc = $urandom_range(1, exp_lat(L) - 1);
         build_model(L, best);
         run_decode(L, best, sc, sl, 1'b0, lat, bok, ba);
         d = seq_diff();
         checks++;
         if (d !== -1) begin
            errors++;
            $display("FAIL rand_seq[%0d] L=%0d: event %0d got %h want %h (%0d vs %0d events)",
                     r, L, d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
         end
         checks++;
         if (lat !== exp_lat(L) + sl) begin
            errors++; $display("FAIL rand_latency[%0d] L=%0d: got %0d want %0d", r, L, lat, exp_lat(L) + sl);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      word_count = '0;
      best_last_pos = '0;
      for (int w = 0; w < 16; w++)
         for (int j = 0; j < 16; j++)
            bp_tab[w][j] = 4'($urandom_range(0, P - 1));
      test_reset();
      test_l2();
      test_l1();
      test_backtrace();
      test_stall();
      test_edges();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/viterbi_sequencer.md
# viterbi_sequencer

Top-level scheduler for the Viterbi decoder datapath. On `start` it walks the trellis for one sentence:
- initialisation over all POS tags;
- recursion over every (word, current POS, previous POS) triple;
- a one-cycle final argmax settle;
- an optional backtrace through the backpointer memory.

It drives the index counters and the valid/first/last strobes that the score accumulator, max-compare unit and backpointer memory consume.

## Interface
Parameters:
- `word_num`, 16, maximum words per sentence
- `word_num_bit`, 4, width of word index
- `POS_num`, 11, number of POS tags
- `POS_num_bit`, 4, width of POS index

Ports:
- `clk`  in  1  rising-edge clock
- `reset_viterbi_sequencer`  in  1  reset. One clock; reset is asynchronous and active-high.
- `start`  in  1  begin decode; sampled in IDLE only
- `word_count`  in  word_num_bit+1  sentence length, latched on accepted `start`
- `stall`  in  1  datapath back-pressure; freezes the sequencer
- `best_last_pos`  in  POS_num_bit  argmax of final column, valid in FINAL
- `bp_data`  in  POS_num_bit  backpointer read data, combinational from `word_idx`/`cur_pos`
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse on DONE
- `word_idx`  out  word_num_bit  current word t
- `cur_pos`  out  POS_num_bit  current tag j
- `prev_pos`  out  POS_num_bit  previous tag i
- `init_valid`  out  1  initialisation step (π·emission) for (0, `cur_pos`)
- `acc_valid`  out  1  recursion step (t, j, i)
- `acc_first`  out  1  with `acc_valid`, `prev_pos`==0: clear running max
- `acc_last`  out  1  with `acc_valid`, `prev_pos`==POS_num-1: commit score and backpointer
- `bt_valid`  out  1  backtrace output: tag `cur_pos` for word `word_idx`

## Operation
- FSM states: IDLE, INIT, RECUR, FINAL, BACKTRACK, DONE.
- **IDLE**
  - `start` with `word_count`==0 goes to DONE.
  - `start` with `word_count` clamped to `word_num` if larger goes to INIT. Indices are zeroed.
- **INIT**
  - One step per cycle, `cur_pos` 0..POS_num-1, `word_idx`=0.
  - After `cur_pos`==POS_num-1: go to RECUR with `word_idx`=1 if count>1, else go to FINAL.
- **RECUR**
  - Loop nesting, innermost first: `prev_pos` 0..POS_num-1, then `cur_pos` 0..POS_num-1, then `word_idx` 1..count-1.
  - Each counter wraps POS_num-1→0 and carries into the next level.
  - The last triple (count-1, POS_num-1, POS_num-1) goes to FINAL.
- **FINAL**
  - One cycle, no strobes.
  - Loads `cur_pos`←`best_last_pos` and `word_idx`←count-1.
- **BACKTRACK**
  - `bt_valid`=1 each cycle.
  - Next `cur_pos`←`bp_data`, `word_idx` decrements.
  - The cycle with `word_idx`==0 goes to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- **`stall`**
  - While high, all registers and state hold.
  - All valid/first/last/done outputs are forced to 0.
  - The step resumes unchanged when `stall` falls.
- **`start` handling**
  - `start` while `busy` is ignored.
  - `start` in the DONE cycle is ignored.
- **Reset**
  - Reset asserted at any time, including mid-decode: IDLE immediately.
  - All outputs read 0 and all counters read 0.

## Timing
- Strobes and indices are registered state outputs. They are valid in the same cycle and have no combinational path from inputs, except the `stall` masking.
- The first INIT step appears the cycle after `start` is accepted.
- Unstalled latency from `start` to `done`:
  - with backtrace: 1 + POS_num + (L-1)·POS_num² + 1 + L + 1 cycles, for L ≥ 1;
  - with L=0: 2.
- For L=2, POS_num=11: INIT 11, RECUR 121, FINAL 1, BACKTRACK 2, so `done` is at cycle 137 after the `start` cycle.
- `busy` rises the cycle after `start` and falls the cycle after `done`.

## Configuration
- `VITERBI_BACKTRACK_EN`
  - **Defined:** BACKTRACK state exists, as described above.
  - **Undefined:**
    - FINAL goes directly to DONE;
    - `bt_valid` is tied to 0;
    - `bp_data` and `best_last_pos` are unused;
    - latency drops by L cycles.

## Structure
- Shared package `viterbi_pkg`:
  - state enum `vseq_state_t`;
  - default sizing constants WORD_NUM=16, POS_NUM=11 and their bit widths.
  - The package is shared with the accumulator and backpointer memory.
- Sub-module `pos_wrap_counter`:
  - POS_num_bit counter with enable, synchronous clear, and load;
  - wraps at POS_num-1 and outputs a wrap flag.
  - Instantiated twice, for `prev_pos` and `cur_pos`.
  - `word_idx` stays local logic because it needs up/down count and load.

## Test plan
- **Reset mid-RECUR:** assert reset at cycle 40 after `start` (L=3) → same cycle `busy`=0 and all indices 0; a new `start` restarts from INIT `cur_pos`=0.
- **L=2, no stall:** `start` → 11 `init_valid`, then 121 `acc_valid` in i-inner order, with `acc_first` at i=0 and `acc_last` at i=10; `done` at cycle 137.
- **L=1:** no `acc_valid` at all; FINAL follows the last INIT; one `bt_valid` with `word_idx`=0 and `cur_pos`=`best_last_pos`.
- **Backtrace chain, L=4:** `best_last_pos`=7, backpointer model returns 3, 9, 0 → `bt_valid` tags (3,7), (2,3), (1,9), (0,0) as (`word_idx`, `cur_pos`).
- **Stall:** `stall` high for 5 cycles at the (1,4,10) step → no strobes during the stall; the same step, with `acc_last`, reissues afterwards; total latency +5.
- **Edge inputs:**
  - `word_count`=0 → `done` 2 cycles after `start` with no valids;
  - `word_count`=20 → behaves as 16;
  - `start` while `busy` → no effect.
